// File: rtl/core_mem_arbiter_pkg.sv
// Shared definitions for the core/VGA shared-memory arbiter: default geometry,
// grant-source encoding and a small width helper.
package core_mem_arbiter_pkg;

  localparam int DEF_NUM_CORES     = 16;
  localparam int DEF_ADDR_W        = 8;
  localparam int DEF_DATA_W        = 8;
  localparam int DEF_VGA_BURST_MAX = 4;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_CORE = 2'd1,
    SRC_VGA  = 2'd2
  } grant_src_e;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Core, VGA and memory-side signals of the shared-memory arbiter.
// master = requesters plus memory model, slave = arbiter.
interface core_mem_arbiter_if #(
  parameter int NUM_CORES = core_mem_arbiter_pkg::DEF_NUM_CORES,
  parameter int ADDR_W    = core_mem_arbiter_pkg::DEF_ADDR_W,
  parameter int DATA_W    = core_mem_arbiter_pkg::DEF_DATA_W
);

  logic [NUM_CORES-1:0]        core_req;
  logic [NUM_CORES-1:0]        core_we;
  logic [NUM_CORES*ADDR_W-1:0] core_addr;
  logic [NUM_CORES*DATA_W-1:0] core_wdata;
  logic [NUM_CORES-1:0]        core_gnt;
  logic [NUM_CORES-1:0]        core_rvalid;
  logic [DATA_W-1:0]           rdata;
  logic                        vga_req;
  logic [ADDR_W-1:0]           vga_addr;
  logic                        vga_gnt;
  logic                        vga_rvalid;
  logic                        mem_en;
  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;

  modport master (
    output core_req, core_we, core_addr, core_wdata, vga_req, vga_addr, mem_rdata,
    input  core_gnt, core_rvalid, rdata, vga_gnt, vga_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, vga_req, vga_addr, mem_rdata,
    output core_gnt, core_rvalid, rdata, vga_gnt, vga_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/core_mem_arbiter_rr_pick.sv
// Round-robin picker: first requester at or above rr_ptr, wrapping to index 0.
// Produces one-hot grant, binary index and an any-request flag.
module rr_pick #(
  parameter int N     = 16,
  parameter int PTR_W = 4
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  // Walk the request vector starting at rr_ptr; the first hit wins.
  always_comb begin
    int   j;
    logic hit;
    gnt = {N{1'b0}};
    idx = {PTR_W{1'b0}};
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j      = (int'(rr_ptr) + k >= N) ? int'(rr_ptr) + k - N : int'(rr_ptr) + k;
      hit    = req[j] & ~any;
      gnt[j] = gnt[j] | hit;
      idx    = hit ? PTR_W'(j) : idx;
      any    = any | hit;
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Single-port shared-memory arbiter: VGA has priority with a bounded burst,
// cores share the remainder round-robin; read data returns one cycle after grant.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES     = DEF_NUM_CORES,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int VGA_BURST_MAX = DEF_VGA_BURST_MAX
) (
  input logic               clk,
  input logic               reset,
  core_mem_arbiter_if.slave bus
);

  localparam int PTR_W    = idx_width(NUM_CORES);
  localparam int STREAK_W = $clog2(VGA_BURST_MAX + 1);

  localparam logic [PTR_W-1:0]    LAST_IDX   = PTR_W'(NUM_CORES - 1);
  localparam logic [PTR_W-1:0]    PTR_ONE    = PTR_W'(1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(VGA_BURST_MAX);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

  logic [PTR_W-1:0]     rr_ptr_r;
  logic [STREAK_W-1:0]  vga_streak_r;
  logic [NUM_CORES-1:0] core_rvalid_r;
  logic                 vga_rvalid_r;

  logic [NUM_CORES-1:0] pick_gnt_s;
  logic [PTR_W-1:0]     pick_idx_s;
  logic                 pick_any_s;
  grant_src_e           src_s;
  logic                 mem_we_s;
  logic [ADDR_W-1:0]    mem_addr_s;
  logic [DATA_W-1:0]    mem_wdata_s;

  rr_pick #(
    .N     (NUM_CORES),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (bus.core_req),
    .rr_ptr (rr_ptr_r),
    .gnt    (pick_gnt_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  // Winner selection: VGA wins unless its streak is saturated while a core waits.
  always_comb begin
    src_s = SRC_NONE;
    if (reset) begin
      src_s = SRC_NONE;
    end else if (bus.vga_req && !((vga_streak_r == STREAK_MAX) && pick_any_s)) begin
      src_s = SRC_VGA;
    end else if (pick_any_s) begin
      src_s = SRC_CORE;
    end else begin
      src_s = SRC_NONE;
    end
  end

  // Memory-side mux from the winning requester; idle cycles drive zeros.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = {DATA_W{1'b0}};
    case (src_s)
      SRC_CORE: begin
        mem_we_s    = bus.core_we[pick_idx_s];
        mem_addr_s  = bus.core_addr[pick_idx_s*ADDR_W +: ADDR_W];
        mem_wdata_s = bus.core_wdata[pick_idx_s*DATA_W +: DATA_W];
      end
      SRC_VGA: begin
        mem_addr_s = bus.vga_addr;
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  // Fairness pointer, VGA burst counter and read-return ownership.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_r      <= {PTR_W{1'b0}};
      vga_streak_r  <= {STREAK_W{1'b0}};
      core_rvalid_r <= {NUM_CORES{1'b0}};
      vga_rvalid_r  <= 1'b0;
    end else begin
      case (src_s)
        SRC_CORE: begin
          rr_ptr_r     <= (pick_idx_s == LAST_IDX) ? {PTR_W{1'b0}} : pick_idx_s + PTR_ONE;
          vga_streak_r <= {STREAK_W{1'b0}};
        end
        SRC_VGA: begin
          vga_streak_r <= (vga_streak_r == STREAK_MAX) ? STREAK_MAX : vga_streak_r + STREAK_ONE;
        end
        default: begin
          if (!bus.vga_req) begin
            vga_streak_r <= {STREAK_W{1'b0}};
          end
        end
      endcase
      core_rvalid_r <= ((src_s == SRC_CORE) && !mem_we_s) ? pick_gnt_s : {NUM_CORES{1'b0}};
      vga_rvalid_r  <= (src_s == SRC_VGA);
    end
  end

  assign bus.core_gnt    = (src_s == SRC_CORE) ? pick_gnt_s : {NUM_CORES{1'b0}};
  assign bus.vga_gnt     = (src_s == SRC_VGA);
  assign bus.mem_en      = (src_s != SRC_NONE);
  assign bus.mem_we      = mem_we_s;
  assign bus.mem_addr    = mem_addr_s;
  assign bus.mem_wdata   = mem_wdata_s;
  assign bus.core_rvalid = core_rvalid_r;
  assign bus.vga_rvalid  = vga_rvalid_r;
  assign bus.rdata       = bus.mem_rdata;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed and randomized bench for core_mem_arbiter, checked every cycle against
// a request-level reference model with an address-hash memory behind it.
module tb_core_mem_arbiter;

  localparam int N    = 16;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int BMAX = 4;

  logic clk = 1'b0;
  logic reset;

  core_mem_arbiter_if #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  core_mem_arbiter #(
    .NUM_CORES     (N),
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .VGA_BURST_MAX (BMAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // requester state: a request stays up until it is granted
  logic          s_req   [N];
  logic          s_we    [N];
  logic [AW-1:0] s_addr  [N];
  logic [DW-1:0] s_wdata [N];
  logic          s_vga_req;
  logic [AW-1:0] s_vga_addr;
  logic          vga_done;

  // reference model state
  int            m_ptr;
  int            m_streak;
  int            m_pend_core;
  logic          m_pend_vga;
  logic [AW-1:0] m_pend_addr;
  int            e_core;
  logic          e_vga;

  // memory emulation
  logic          env_rd;
  logic [AW-1:0] env_addr;

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return DW'(a * 8'd37 + 8'h5B);
  endfunction

  always @(posedge clk) begin
    if (env_rd) bus.mem_rdata <= rom(env_addr);
    else        bus.mem_rdata <= DW'($urandom);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      s_req[i] = 1'b0; s_we[i] = 1'b0; s_addr[i] = '0; s_wdata[i] = '0;
    end
    s_vga_req = 1'b0; s_vga_addr = '0;
  endtask

  task automatic set_core(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    s_req[i] = 1'b1; s_we[i] = we; s_addr[i] = a; s_wdata[i] = d;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.core_req[i]              = s_req[i];
      bus.core_we[i]               = s_we[i];
      bus.core_addr[i*AW +: AW]    = s_addr[i];
      bus.core_wdata[i*DW +: DW]   = s_wdata[i];
    end
    bus.vga_req  = s_vga_req;
    bus.vga_addr = s_vga_addr;
  endtask

  // Decide this cycle's winner from the arbitration rules and compare all outputs.
  task automatic eval_and_compare();
    logic [N-1:0]  r;
    logic [N-1:0]  erv;
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    for (int i = 0; i < N; i++) r[i] = s_req[i];
    if (reset) begin
      m_ptr = 0; m_streak = 0; m_pend_core = -1; m_pend_vga = 1'b0;
    end
    e_core = -1;
    e_vga  = 1'b0;
    if (!reset) begin
      if (s_vga_req && !(m_streak == BMAX && r != '0)) begin
        e_vga = 1'b1;
      end else begin
        for (int i = m_ptr; i < N; i++) if (e_core < 0 && r[i]) e_core = i;
        for (int i = 0; i < m_ptr; i++) if (e_core < 0 && r[i]) e_core = i;
      end
    end
    ew = 1'b0; ea = '0; ed = '0;
    if (e_core >= 0) begin
      ew = s_we[e_core]; ea = s_addr[e_core]; ed = s_wdata[e_core];
    end else if (e_vga) begin
      ea = s_vga_addr;
    end
    erv = '0;
    if (m_pend_core >= 0) erv[m_pend_core] = 1'b1;
    chk("core_gnt",    64'(bus.core_gnt),    (e_core >= 0) ? (64'd1 << e_core) : 64'd0);
    chk("vga_gnt",     64'(bus.vga_gnt),     64'(e_vga));
    chk("mem_en",      64'(bus.mem_en),      64'((e_core >= 0) || e_vga));
    chk("mem_we",      64'(bus.mem_we),      64'(ew));
    chk("mem_addr",    64'(bus.mem_addr),    64'(ea));
    chk("mem_wdata",   64'(bus.mem_wdata),   64'(ed));
    chk("core_rvalid", 64'(bus.core_rvalid), 64'(erv));
    chk("vga_rvalid",  64'(bus.vga_rvalid),  64'(m_pend_vga));
    chk("rdata_pass",  64'(bus.rdata),       64'(bus.mem_rdata));
    if (m_pend_core >= 0 || m_pend_vga) chk("rdata", 64'(bus.rdata), 64'(rom(m_pend_addr)));
    env_rd   = bus.mem_en && !bus.mem_we;
    env_addr = bus.mem_addr;
  endtask

  task automatic model_advance();
    m_pend_core = -1;
    m_pend_vga  = 1'b0;
    if (e_core >= 0) begin
      m_ptr    = (e_core + 1) % N;
      m_streak = 0;
      if (!s_we[e_core]) begin
        m_pend_core = e_core; m_pend_addr = s_addr[e_core];
      end
      s_req[e_core] = 1'b0;
    end else if (e_vga) begin
      m_streak    = (m_streak < BMAX) ? m_streak + 1 : BMAX;
      m_pend_vga  = 1'b1;
      m_pend_addr = s_vga_addr;
      vga_done    = 1'b1;
    end else if (!s_vga_req) begin
      m_streak = 0;
    end
  endtask

  task automatic cyc();
    drive();
    #2;
    eval_and_compare();
  endtask

  task automatic next();
    model_advance();
    @(negedge clk);
  endtask

  int dens [3] = '{8, 30, 3};
  int vdens[3] = '{30, 70, 95};

  initial begin
    reset = 1'b1; vga_done = 1'b0; env_rd = 1'b0; env_addr = '0;
    m_ptr = 0; m_streak = 0; m_pend_core = -1; m_pend_vga = 1'b0; m_pend_addr = '0;
    clear_stim();

    // requests pending during reset must not be granted
    for (int i = 0; i < N; i++) set_core(i, 1'b0, AW'(i), '0);
    s_vga_req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cyc();
      chk("rst_core_gnt", 64'(bus.core_gnt), 64'd0);
      chk("rst_vga_gnt",  64'(bus.vga_gnt),  64'd0);
      chk("rst_mem_en",   64'(bus.mem_en),   64'd0);
      chk("rst_rvalid",   64'(bus.core_rvalid), 64'd0);
      next();
    end

    // reads from cores 0,3,7 granted back to back, data one cycle later
    reset = 1'b0; clear_stim();
    set_core(0, 1'b0, 8'h00, 8'h00); set_core(3, 1'b0, 8'h33, 8'h00); set_core(7, 1'b0, 8'h77, 8'h00);
    cyc(); chk("d036_gnt0", 64'(bus.core_gnt), 64'h0001); chk("d036_addr0", 64'(bus.mem_addr), 64'h00); next();
    cyc(); chk("d036_gnt3", 64'(bus.core_gnt), 64'h0008); chk("d036_rv0", 64'(bus.core_rvalid), 64'h0001);
           chk("d036_rd0", 64'(bus.rdata), 64'h5B); next();
    cyc(); chk("d036_gnt7", 64'(bus.core_gnt), 64'h0080); chk("d036_rv3", 64'(bus.core_rvalid), 64'h0008);
           chk("d036_rd3", 64'(bus.rdata), 64'hBA); next();
    cyc(); chk("d036_idle", 64'(bus.core_gnt), 64'h0000); chk("d036_rv7", 64'(bus.core_rvalid), 64'h0080);
           chk("d036_rd7", 64'(bus.rdata), 64'h8E); next();

    // wrap after core 15, pointer then sits at 1
    set_core(15, 1'b0, 8'hF0, 8'h00);
    cyc(); chk("d037_gnt15", 64'(bus.core_gnt), 64'h8000); next();
    set_core(0, 1'b0, 8'h01, 8'h00); set_core(14, 1'b0, 8'hE0, 8'h00);
    cyc(); chk("d037_gnt0", 64'(bus.core_gnt), 64'h0001); next();
    set_core(0, 1'b0, 8'h02, 8'h00);
    cyc(); chk("d037_gnt14", 64'(bus.core_gnt), 64'h4000); next();
    cyc(); chk("d037_gnt0b", 64'(bus.core_gnt), 64'h0001); next();

    // core 5 write
    set_core(5, 1'b1, 8'h10, 8'hAB);
    cyc(); chk("d039_gnt", 64'(bus.core_gnt), 64'h0020); chk("d039_en", 64'(bus.mem_en), 64'd1);
           chk("d039_we", 64'(bus.mem_we), 64'd1); chk("d039_addr", 64'(bus.mem_addr), 64'h10);
           chk("d039_wdata", 64'(bus.mem_wdata), 64'hAB); next();
    cyc(); chk("d039_norv", 64'(bus.core_rvalid), 64'h0000); next();

    // VGA burst limit against a waiting core 2
    s_vga_req = 1'b1; s_vga_addr = 8'h40; set_core(2, 1'b0, 8'h22, 8'h00);
    for (int c = 0; c < BMAX; c++) begin
      cyc(); chk("d038_vga", 64'(bus.vga_gnt), 64'd1); chk("d038_nocore", 64'(bus.core_gnt), 64'd0);
             chk("d038_vaddr", 64'(bus.mem_addr), 64'h40); next();
    end
    cyc(); chk("d038_core2", 64'(bus.core_gnt), 64'h0004); chk("d038_vgaoff", 64'(bus.vga_gnt), 64'd0);
           chk("d038_vrv", 64'(bus.vga_rvalid), 64'd1); next();
    cyc(); chk("d038_vgaback", 64'(bus.vga_gnt), 64'd1); chk("d038_rv2", 64'(bus.core_rvalid), 64'h0004);
           chk("d038_rd2", 64'(bus.rdata), 64'h45); next();

    // idle bus drives zeros, pointer keeps its value
    clear_stim();
    for (int c = 0; c < 10; c++) begin
      cyc(); chk("d041_en", 64'(bus.mem_en), 64'd0); chk("d041_addr", 64'(bus.mem_addr), 64'd0);
             chk("d041_we", 64'(bus.mem_we), 64'd0); chk("d041_wdata", 64'(bus.mem_wdata), 64'd0); next();
    end
    set_core(2, 1'b0, 8'h02, 8'h00); set_core(3, 1'b0, 8'h03, 8'h00);
    cyc(); chk("d041_ptr", 64'(bus.core_gnt), 64'h0008); next();
    cyc(); chk("d041_ptr2", 64'(bus.core_gnt), 64'h0004); next();

    // reset in the middle of a core 4 read grant
    set_core(4, 1'b0, 8'h44, 8'h00);
    cyc(); chk("d040_gnt4", 64'(bus.core_gnt), 64'h0010);
    reset = 1'b1;
    #1;
    eval_and_compare();
    chk("d040_gnt_rst", 64'(bus.core_gnt), 64'd0); chk("d040_en_rst", 64'(bus.mem_en), 64'd0);
    next();
    reset = 1'b0; clear_stim();
    set_core(3, 1'b0, 8'h30, 8'h00); set_core(5, 1'b0, 8'h50, 8'h00);
    cyc(); chk("d040_norv", 64'(bus.core_rvalid), 64'd0); chk("d040_ptr0", 64'(bus.core_gnt), 64'h0008); next();

    // randomized traffic at three load mixes, with occasional resets
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 600; c++) begin
        reset = ($urandom_range(0, 299) == 0);
        for (int i = 0; i < N; i++) begin
          if (!s_req[i]) begin
            if ($urandom_range(0, 99) < dens[ph])
              set_core(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
          end else if ($urandom_range(0, 63) == 0) begin
            s_req[i] = 1'b0;
          end
        end
        if (vga_done || !s_vga_req) begin
          s_vga_req  = ($urandom_range(0, 99) < vdens[ph]);
          s_vga_addr = AW'($urandom);
          vga_done   = 1'b0;
        end
        cyc();
        next();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 16, number of requesting cores.
REQ-002 SHALL have parameter ADDR_W, default 8, shared-memory address width.
REQ-003 SHALL have parameter DATA_W, default 8, shared-memory data width.
REQ-004 SHALL have parameter VGA_BURST_MAX, default 4, max consecutive VGA grants while any core waits.
REQ-005 Ports: clk  in  1  sole clock; all state on posedge.
REQ-006 Ports: reset  in  1  asynchronous, active-high.
REQ-007 Ports: core_req  in  NUM_CORES  per-core access request.
REQ-008 Ports: core_we  in  NUM_CORES  per-core write strobe, valid with core_req.
REQ-009 Ports: core_addr  in  NUM_CORES*ADDR_W  flattened; core i at [i*ADDR_W +: ADDR_W].
REQ-010 Ports: core_wdata  in  NUM_CORES*DATA_W  flattened, same packing.
REQ-011 Ports: core_gnt  out  NUM_CORES  one-hot grant, combinational, same cycle as mem_en.
REQ-012 Ports: core_rvalid  out  NUM_CORES  one-hot read-data-valid, registered.
REQ-013 Ports: rdata  out  DATA_W  read data broadcast to all cores and VGA.
REQ-014 Ports: vga_req  in  1  VGA read request; vga_addr  in  ADDR_W  read address.
REQ-015 Ports: vga_gnt  out  1  VGA grant; vga_rvalid  out  1  VGA read-data-valid.
REQ-016 Ports: mem_en, mem_we  out  1  memory strobe/write; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W.
REQ-017 Ports: mem_rdata  in  DATA_W  synchronous memory output, valid 1 cycle after mem_en & ~mem_we.

Function
REQ-018 At most one of {core_gnt bits, vga_gnt} SHALL be high per cycle; mem_en = |core_gnt | vga_gnt.
REQ-019 Requester SHALL hold req/we/addr/wdata stable until the cycle its grant is high; grant consumes exactly one access.
REQ-020 VGA SHALL win whenever vga_req=1, unless vga_streak==VGA_BURST_MAX and |core_req, in which case a core wins.
REQ-021 vga_streak (counter, width clog2(VGA_BURST_MAX+1)) SHALL increment on each vga_gnt, saturate at VGA_BURST_MAX, clear on any core grant or any cycle with vga_req=0.
REQ-022 Core choice SHALL be round-robin: lowest index i >= rr_ptr with core_req[i], else wrap to lowest index < rr_ptr.
REQ-023 After core i granted, rr_ptr SHALL become (i+1) mod NUM_CORES; unchanged otherwise.
REQ-024 mem_addr/mem_we/mem_wdata SHALL be muxed from the granted requester; VGA: mem_we=0, mem_wdata=0; no grant: all mem_* = 0.
REQ-025 Read grant SHALL set owner register; next cycle core_rvalid[owner] or vga_rvalid =1 for one cycle, rdata=mem_rdata.
REQ-026 Write grants SHALL produce no rvalid; back-to-back grants each cycle SHALL be supported (throughput 1 access/cycle).
REQ-027 rdata SHALL equal mem_rdata combinationally; only rvalid qualifies it.
REQ-028 core_req dropped before grant SHALL be ignored without state change.

Reset
REQ-029 Asserting reset SHALL immediately clear rr_ptr=0, vga_streak=0, core_rvalid=0, vga_rvalid=0, owner state.
REQ-030 While reset=1, core_gnt, vga_gnt, mem_en SHALL be 0 regardless of requests.
REQ-031 Read in flight when reset asserts SHALL be dropped (no rvalid after release).
REQ-032 First grant SHALL be possible in the first clock edge cycle after reset deasserts.

Structure
REQ-033 NUM_CORES, ADDR_W, DATA_W defaults and flattened-bus range macros SHALL live in the shared SharedInc/Ranges.def.v definitions.
REQ-034 Round-robin selection SHALL be a sub-module rr_pick (inputs req vector, rr_ptr; outputs one-hot gnt, binary index, any).
REQ-035 Block SHALL contain no memory array; memory is external.

Verification
REQ-036 Cores 0,3,7 req reads, rr_ptr=0, no VGA -> grants 0,3,7 on consecutive cycles; rvalid bits follow one cycle later with matching rdata.
REQ-037 Core 15 granted, then cores 0 and 14 req -> core 0 granted first (wrap), rr_ptr becomes 1.
REQ-038 vga_req held high, core 2 req held, VGA_BURST_MAX=4 -> 4 vga_gnt, 1 core_gnt[2], then VGA resumes.
REQ-039 Core 5 write addr 0x10 data 0xAB -> mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xAB same cycle; no rvalid.
REQ-040 Reset asserted mid-cycle after core 4 read grant -> core_rvalid stays 0, gnt/mem_en 0 immediately, rr_ptr=0 after release.
REQ-041 No requests for 10 cycles -> mem_en=0, all mem_* = 0, vga_streak=0, rr_ptr unchanged.
